fetch_pc_stall_unit: RTL and testbench
======================================

Name: fetch_pc_stall_unit

Overview:
- Fetch-stage PC sequencer sitting directly upstream of the decode-stage control block.
- Generates the next instruction-memory read address and tracks the PC/valid of the instruction presented to decode.
- Consumes decode hazard flags, executing a counted stall FSM while they are active. Also consumes the decode branch prediction and the execute-stage redirect.
- Tells the decode→execute pipeline register when to load a bubble, and keeps stall/redirect performance counters.

Parameters:
RESET_PC, 32'h4000_0000, address of first instruction fetched after reset
PC_WIDTH, 32, PC and address width

Ports:
clk  input  1  system clock
rst  input  1  synchronous active-high reset
decode_hazard_2_cyc  input  1  decode operand depends on execute-stage rd
decode_hazard_1_cyc  input  1  decode operand depends on memory-stage rd
br_pred_taken  input  1  decode branch predicted taken (valid only with decode is_br)
br_pred_target  input  PC_WIDTH  predicted branch target from decode
redirect_valid  input  1  execute-stage mispredict/jalr correction
redirect_pc  input  PC_WIDTH  corrected PC
perf_clr  input  1  synchronous clear of both perf counters
pc_req  output  PC_WIDTH  combinational imem read address (sync-read imem, data next cycle)
pc_decode  output  PC_WIDTH  PC of instruction currently at decode (registered)
decode_valid  output  1  instruction at decode is real (registered)
stall  output  1  hold decode register/imem address this cycle (combinational)
bubble_execute  output  1  decode→execute register loads NOP 32'h0000_0013 (combinational)
stall_cycles  output  32  count of stall cycles
redirect_count  output  32  count of redirects

Behaviour:
- Reset values: pc_decode=RESET_PC, decode_valid=0, state=RUN, cnt=0, stall_cycles=0, redirect_count=0. While rst=1: pc_req=RESET_PC, stall=0, bubble_execute=1.
- Hazard qualification: hz2 = decode_hazard_2_cyc & decode_valid; hz1 = decode_hazard_1_cyc & decode_valid.
- FSM states:
  - RUN: hazard inputs sampled.
  - STALL: hazard inputs ignored; 1-bit countdown cnt.
- pc_req priority, evaluated combinationally each cycle:
  1. redirect_valid → redirect_pc.
  2. stall → pc_decode.
  3. !decode_valid → pc_decode.
  4. br_pred_taken & decode_valid → br_pred_target.
  5. Otherwise → pc_decode + 4, mod 2^32.
- stall is defined as: !redirect_valid & ((RUN & (hz2|hz1)) | STALL).
- bubble_execute = redirect_valid | stall | !decode_valid.
- Registered updates each cycle (rst=0): pc_decode <= pc_req.
  - decode_valid <= 1, except it holds its value during stall.
  - A stall cycle re-reads the same address, so the imem output stays stable.
- RUN transitions:
  - RUN & hz2 & !redirect: stall this cycle; cnt<=1; next state STALL. Total 2 stall cycles.
  - RUN & hz1 & !hz2 & !redirect: stall this cycle only; stay in RUN. Total 1 cycle.
  - If hz2 and hz1 are both set, hz2 wins (2 cycles).
- STALL transitions: stall asserted; when cnt=1, cnt<=0 and state<=RUN.
- Redirect:
  - redirect_valid in any state forces state<=RUN and cnt<=0, aborting the stall.
  - The wrong-path decode instruction is squashed via bubble_execute the same cycle.
  - The corrected instruction arrives at decode next cycle with decode_valid=1.
- Predicted-taken branch that also has a hazard: the stall wins. The target is fetched on the first non-stall cycle, when the hazard has cleared and the prediction is still presented.
- Perf counters:
  - stall_cycles increments on each cycle with stall=1.
  - redirect_count increments on each cycle with redirect_valid=1.
  - Both wrap 32'hFFFF_FFFF→0.
  - perf_clr has priority over increment.
  - Counters are unaffected by stall/redirect state otherwise; rst clears them.

Test Plan:
- Reset release → cycle 0: pc_req=4000_0000, decode_valid=0, bubble_execute=1. Cycle 1: pc_decode=4000_0000, decode_valid=1, pc_req=4000_0004.
- hz2 at pc_decode=4000_0008 → stall=1 for exactly 2 cycles with pc_req=4000_0008, bubble_execute=1. Cycle 3: pc_req=4000_000C. stall_cycles=2.
- hz1 alone, and hz1+hz2 together → 1 and 2 stall cycles respectively. A hazard held high throughout STALL does not extend it beyond 2.
- Predicted-taken branch at 4000_0010 with target 4000_0100, no hazard → pc_req=4000_0100 that cycle. Next cycle pc_decode=4000_0100, no bubble.
- redirect_valid with redirect_pc=4000_0200 during the first STALL cycle → stall=0, bubble_execute=1, state RUN. Next cycle pc_decode=4000_0200, decode_valid=1. redirect_count=1.
- Preload stall_cycles=FFFF_FFFF then one stall → 0. perf_clr concurrent with stall → 0.

Source files
------------

// File: rtl/fetch_pc_stall_unit.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | fetch_pc_stall_unit: fetch PC sequencer with hazard stall FSM, branch      |
// | prediction/redirect steering and stall/redirect performance counters.      |
// | Revision: 1.0                                                              |
// +----------------------------------------------------------------------------+
module fetch_pc_stall_unit #(
    parameter int                  PC_WIDTH = 32,
    parameter logic [PC_WIDTH-1:0] RESET_PC = 'h4000_0000
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                decode_hazard_2_cyc,
    input  logic                decode_hazard_1_cyc,
    input  logic                br_pred_taken,
    input  logic [PC_WIDTH-1:0] br_pred_target,
    input  logic                redirect_valid,
    input  logic [PC_WIDTH-1:0] redirect_pc,
    input  logic                perf_clr,
    output logic [PC_WIDTH-1:0] pc_req,
    output logic [PC_WIDTH-1:0] pc_decode,
    output logic                decode_valid,
    output logic                stall,
    output logic                bubble_execute,
    output logic [31:0]         stall_cycles,
    output logic [31:0]         redirect_count
);

    typedef enum logic [0:0] {
        ST_RUN   = 1'b0,
        ST_STALL = 1'b1
    } state_t;

    state_t              state_q, state_d;
    logic                cnt_q, cnt_d;
    logic [PC_WIDTH-1:0] pc_decode_q, pc_decode_d;
    logic                decode_valid_q, decode_valid_d;
    logic [31:0]         stall_cycles_q, stall_cycles_d;
    logic [31:0]         redirect_count_q, redirect_count_d;

    logic hz2, hz1, stall_raw;

    always_comb begin
        hz2       = decode_hazard_2_cyc & decode_valid_q;
        hz1       = decode_hazard_1_cyc & decode_valid_q;
        stall_raw = !redirect_valid &
                    (((state_q == ST_RUN) & (hz2 | hz1)) | (state_q == ST_STALL));

        stall          = stall_raw & !rst;
        bubble_execute = rst | redirect_valid | stall_raw | !decode_valid_q;

        if (rst)                                 pc_req = RESET_PC;
        else if (redirect_valid)                 pc_req = redirect_pc;
        else if (stall_raw)                      pc_req = pc_decode_q;
        else if (!decode_valid_q)                pc_req = pc_decode_q;
        else if (br_pred_taken & decode_valid_q) pc_req = br_pred_target;
        else                                     pc_req = pc_decode_q + PC_WIDTH'(4);
    end

    // Stall FSM: a 2-cycle hazard spends one cycle in RUN and one in STALL.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        if (redirect_valid) begin
            state_d = ST_RUN;
            cnt_d   = 1'b0;
        end else if (state_q == ST_RUN) begin
            if (hz2) begin
                state_d = ST_STALL;
                cnt_d   = 1'b1;
            end
        end else if (cnt_q) begin
            state_d = ST_RUN;
            cnt_d   = 1'b0;
        end
    end

    always_comb begin
        pc_decode_d    = pc_req;
        decode_valid_d = stall_raw ? decode_valid_q : 1'b1;

        stall_cycles_d = stall_cycles_q;
        if (perf_clr)       stall_cycles_d = 32'd0;
        else if (stall_raw) stall_cycles_d = stall_cycles_q + 32'd1;

        redirect_count_d = redirect_count_q;
        if (perf_clr)            redirect_count_d = 32'd0;
        else if (redirect_valid) redirect_count_d = redirect_count_q + 32'd1;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q          <= ST_RUN;
            cnt_q            <= 1'b0;
            pc_decode_q      <= RESET_PC;
            decode_valid_q   <= 1'b0;
            stall_cycles_q   <= 32'd0;
            redirect_count_q <= 32'd0;
        end else begin
            state_q          <= state_d;
            cnt_q            <= cnt_d;
            pc_decode_q      <= pc_decode_d;
            decode_valid_q   <= decode_valid_d;
            stall_cycles_q   <= stall_cycles_d;
            redirect_count_q <= redirect_count_d;
        end
    end

    assign pc_decode      = pc_decode_q;
    assign decode_valid   = decode_valid_q;
    assign stall_cycles   = stall_cycles_q;
    assign redirect_count = redirect_count_q;

endmodule
`default_nettype wire

// File: tb/tb_fetch_pc_stall_unit.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | tb_fetch_pc_stall_unit: directed and randomized bench for fetch_pc_stall.  |
// | Revision: 1.0                                                              |
// +----------------------------------------------------------------------------+
module tb_fetch_pc_stall_unit;

    localparam logic [31:0] RST_PC = 32'h4000_0000;

    logic        clk = 1'b0;
    logic        rst;
    logic        h2_i, h1_i, bt_i, rv_i, clr_i;
    logic [31:0] bta_i, rpc_i;
    logic [31:0] pc_req, pc_decode, stall_cycles, redirect_count;
    logic        decode_valid, stall, bubble_execute;

    int total = 0;
    int bad   = 0;

    // Reference model: pc/valid of decode, remaining stall cycles, counters.
    logic [31:0] m_pc, m_req, m_sc, m_rc;
    logic        m_valid, m_stall, m_bub;
    int          m_left;

    fetch_pc_stall_unit #(.PC_WIDTH(32), .RESET_PC(RST_PC)) dut (
        .clk                 (clk),
        .rst                 (rst),
        .decode_hazard_2_cyc (h2_i),
        .decode_hazard_1_cyc (h1_i),
        .br_pred_taken       (bt_i),
        .br_pred_target      (bta_i),
        .redirect_valid      (rv_i),
        .redirect_pc         (rpc_i),
        .perf_clr            (clr_i),
        .pc_req              (pc_req),
        .pc_decode           (pc_decode),
        .decode_valid        (decode_valid),
        .stall               (stall),
        .bubble_execute      (bubble_execute),
        .stall_cycles        (stall_cycles),
        .redirect_count      (redirect_count)
    );

    always #5 clk = ~clk;

    initial begin
        #2_000_000;
        $display("FAIL watchdog timeout total=%0d bad=%0d", total, bad);
        $fatal(1);
    end

    task automatic m_eval();
        m_stall = !rv_i && (m_left > 0 || (m_valid && (h2_i || h1_i)));
        if (rv_i)                  m_req = rpc_i;
        else if (m_stall)          m_req = m_pc;
        else if (!m_valid)         m_req = m_pc;
        else if (bt_i && m_valid)  m_req = bta_i;
        else                       m_req = m_pc + 32'd4;
        m_bub = rv_i || m_stall || !m_valid;
    endtask

    task automatic m_step();
        if (rv_i)                     m_left = 0;
        else if (m_left > 0)          m_left = m_left - 1;
        else if (m_valid && h2_i)     m_left = 1;
        else                          m_left = 0;
        m_sc    = clr_i ? 32'd0 : m_sc + (m_stall ? 32'd1 : 32'd0);
        m_rc    = clr_i ? 32'd0 : m_rc + (rv_i ? 32'd1 : 32'd0);
        m_valid = m_stall ? m_valid : 1'b1;
        m_pc    = m_req;
    endtask

    task automatic drive(input logic h2, input logic h1, input logic bt,
                         input logic [31:0] bta, input logic rv,
                         input logic [31:0] rpc, input logic clr);
        h2_i = h2; h1_i = h1; bt_i = bt; bta_i = bta;
        rv_i = rv; rpc_i = rpc; clr_i = clr;
        #2;
        m_eval();
    endtask

    task automatic advance();
        m_step();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        drive(1'b1, 1'b1, 1'b1, 32'h4000_0800, 1'b0, 32'h0, 1'b0);
        repeat (2) @(posedge clk);
        #3;
        total++; if (pc_req !== RST_PC) begin bad++; $display("FAIL rst_pc_req got=%h want=%h", pc_req, RST_PC); end
        total++; if (stall !== 1'b0) begin bad++; $display("FAIL rst_stall got=%b want=0", stall); end
        total++; if (bubble_execute !== 1'b1) begin bad++; $display("FAIL rst_bubble got=%b want=1", bubble_execute); end
        total++; if (pc_decode !== RST_PC || decode_valid !== 1'b0) begin bad++; $display("FAIL rst_decode got=%h/%b want=%h/0", pc_decode, decode_valid, RST_PC); end
        total++; if (stall_cycles !== 32'd0 || redirect_count !== 32'd0) begin bad++; $display("FAIL rst_counters got=%h/%h want=0/0", stall_cycles, redirect_count); end
        m_pc = RST_PC; m_valid = 1'b0; m_left = 0; m_sc = 32'd0; m_rc = 32'd0;
        rst = 1'b0;
        drive(1'b0, 1'b0, 1'b0, 32'h0, 1'b0, 32'h0, 1'b0);
        total++; if (pc_req !== 32'h4000_0000 || decode_valid !== 1'b0 || bubble_execute !== 1'b1) begin bad++; $display("FAIL cyc0 got pc_req=%h valid=%b bub=%b want 40000000/0/1", pc_req, decode_valid, bubble_execute); end
        advance();
        drive(1'b0, 1'b0, 1'b0, 32'h0, 1'b0, 32'h0, 1'b0);
        total++; if (pc_decode !== 32'h4000_0000 || decode_valid !== 1'b1 || pc_req !== 32'h4000_0004) begin bad++; $display("FAIL cyc1 got pcd=%h valid=%b req=%h want 40000000/1/40000004", pc_decode, decode_valid, pc_req); end
        advance();
    endtask

    task automatic test_hz2();
        for (int k = 0; k < 8 && m_pc != 32'h4000_0008; k++) begin
            drive(1'b0, 1'b0, 1'b0, 32'h0, 1'b0, 32'h0, 1'b0);
            advance();
        end
        for (int i = 0; i < 2; i++) begin
            drive(1'b1, 1'b0, 1'b0, 32'h0, 1'b0, 32'h0, 1'b0);
            total++; if (stall !== 1'b1 || pc_req !== 32'h4000_0008 || bubble_execute !== 1'b1) begin bad++; $display("FAIL hz2_cyc%0d got stall=%b req=%h bub=%b want 1/40000008/1", i, stall, pc_req, bubble_execute); end
            advance();
        end
        drive(1'b0, 1'b0, 1'b0, 32'h0, 1'b0, 32'h0, 1'b0);
        total++; if (stall !== 1'b0 || pc_req !== 32'h4000_000C) begin bad++; $display("FAIL hz2_release got stall=%b req=%h want 0/4000000c", stall, pc_req); end
        total++; if (stall_cycles !== 32'd2) begin bad++; $display("FAIL hz2_count got=%0d want=2", stall_cycles); end
        advance();
    endtask

    task automatic test_hz1_and_both();
        for (int mode = 0; mode < 2; mode++) begin
            int n = 0;
            for (int i = 0; i < 4; i++) begin
                drive(mode == 1 && i < 2, i < (mode == 1 ? 2 : 1), 1'b0, 32'h0, 1'b0, 32'h0, 1'b0);
                if (stall === 1'b1) n++;
                total++; if (stall !== m_stall) begin bad++; $display("FAIL hz_mode%0d_cyc%0d stall got=%b want=%b", mode, i, stall, m_stall); end
                advance();
            end
            total++; if (n != (mode == 1 ? 2 : 1)) begin bad++; $display("FAIL hz_mode%0d_len got=%0d want=%0d", mode, n, mode == 1 ? 2 : 1); end
        end
    endtask

    task automatic test_branch();
        drive(1'b0, 1'b0, 1'b1, 32'h4000_0100, 1'b0, 32'h0, 1'b0);
        total++; if (pc_req !== 32'h4000_0100 || bubble_execute !== 1'b0 || stall !== 1'b0) begin bad++; $display("FAIL br_taken got req=%h bub=%b stall=%b want 40000100/0/0", pc_req, bubble_execute, stall); end
        advance();
        drive(1'b0, 1'b0, 1'b0, 32'h0, 1'b0, 32'h0, 1'b0);
        total++; if (pc_decode !== 32'h4000_0100 || decode_valid !== 1'b1 || bubble_execute !== 1'b0) begin bad++; $display("FAIL br_target_decode got pcd=%h valid=%b bub=%b want 40000100/1/0", pc_decode, decode_valid, bubble_execute); end
        advance();
        drive(1'b0, 1'b1, 1'b1, 32'h4000_0300, 1'b0, 32'h0, 1'b0);
        total++; if (pc_req !== 32'h4000_0104 || stall !== 1'b1) begin bad++; $display("FAIL br_hazard got req=%h stall=%b want 40000104/1", pc_req, stall); end
        advance();
        drive(1'b0, 1'b0, 1'b1, 32'h4000_0300, 1'b0, 32'h0, 1'b0);
        total++; if (pc_req !== 32'h4000_0300 || stall !== 1'b0) begin bad++; $display("FAIL br_after_hazard got req=%h stall=%b want 40000300/0", pc_req, stall); end
        advance();
    endtask

    task automatic test_redirect();
        drive(1'b1, 1'b0, 1'b0, 32'h0, 1'b0, 32'h0, 1'b0);
        total++; if (stall !== 1'b1) begin bad++; $display("FAIL redir_pre_stall got=%b want=1", stall); end
        advance();
        drive(1'b0, 1'b0, 1'b0, 32'h0, 1'b1, 32'h4000_0200, 1'b0);
        total++; if (stall !== 1'b0 || bubble_execute !== 1'b1 || pc_req !== 32'h4000_0200) begin bad++; $display("FAIL redir_abort got stall=%b bub=%b req=%h want 0/1/40000200", stall, bubble_execute, pc_req); end
        advance();
        drive(1'b0, 1'b0, 1'b0, 32'h0, 1'b0, 32'h0, 1'b0);
        total++; if (pc_decode !== 32'h4000_0200 || decode_valid !== 1'b1 || stall !== 1'b0) begin bad++; $display("FAIL redir_next got pcd=%h valid=%b stall=%b want 40000200/1/0", pc_decode, decode_valid, stall); end
        total++; if (redirect_count !== 32'd1) begin bad++; $display("FAIL redir_count got=%0d want=1", redirect_count); end
        advance();
    endtask

    task automatic test_perf_clr();
        drive(1'b0, 1'b1, 1'b0, 32'h0, 1'b0, 32'h0, 1'b1);
        advance();
        drive(1'b0, 1'b0, 1'b0, 32'h0, 1'b0, 32'h0, 1'b0);
        total++; if (stall_cycles !== 32'd0 || redirect_count !== 32'd0) begin bad++; $display("FAIL clr_with_stall got=%0d/%0d want=0/0", stall_cycles, redirect_count); end
        advance();
        drive(1'b0, 1'b1, 1'b0, 32'h0, 1'b0, 32'h0, 1'b0);
        advance();
        drive(1'b0, 1'b0, 1'b0, 32'h0, 1'b0, 32'h0, 1'b0);
        total++; if (stall_cycles !== 32'd1) begin bad++; $display("FAIL count_after_clr got=%0d want=1", stall_cycles); end
        advance();
    endtask

    task automatic test_random();
        for (int i = 0; i < 500; i++) begin
            drive(($urandom % 6) == 0, ($urandom % 5) == 0, ($urandom % 4) == 0,
                  RST_PC | ($urandom & 32'h0000_3FFC), ($urandom % 10) == 0,
                  RST_PC | ($urandom & 32'h0000_FFFC), ($urandom % 60) == 0);
            total++; if (pc_req !== m_req) begin bad++; $display("FAIL rnd%0d pc_req got=%h want=%h", i, pc_req, m_req); end
            total++; if (stall !== m_stall || bubble_execute !== m_bub) begin bad++; $display("FAIL rnd%0d stall/bub got=%b/%b want=%b/%b", i, stall, bubble_execute, m_stall, m_bub); end
            total++; if (pc_decode !== m_pc || decode_valid !== m_valid) begin bad++; $display("FAIL rnd%0d decode got=%h/%b want=%h/%b", i, pc_decode, decode_valid, m_pc, m_valid); end
            total++; if (stall_cycles !== m_sc || redirect_count !== m_rc) begin bad++; $display("FAIL rnd%0d counters got=%0d/%0d want=%0d/%0d", i, stall_cycles, redirect_count, m_sc, m_rc); end
            advance();
        end
    endtask

    initial begin
        rst = 1'b1;
        h2_i = 1'b0; h1_i = 1'b0; bt_i = 1'b0; rv_i = 1'b0; clr_i = 1'b0;
        bta_i = 32'h0; rpc_i = 32'h0;
        @(posedge clk);
        #1;
        test_reset();
        test_hz2();
        test_hz1_and_both();
        test_branch();
        test_redirect();
        test_perf_clr();
        test_random();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
`default_nettype wire
